// File: rtl/m_unit_scheduler_if.sv
// m_unit_scheduler_if: EX-stage issue, hazard, writeback and mul/div datapath signals for the M-unit scheduler
interface m_unit_scheduler_if;
  logic        issue_valid;
  logic [2:0]  issue_func3;
  logic [4:0]  issue_rd;
  logic [31:0] issue_op1;
  logic [31:0] issue_op2;
  logic        pipeline_flush;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic        ex_rs1_used;
  logic        ex_rs2_used;
  logic        ex_slot_free;
  logic        mdu_done;
  logic [31:0] mdu_result;
  logic        issue_ready;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        m_unit_ready;
  logic [31:0] m_unit_result;
  logic [4:0]  m_unit_dest;
  logic        m_unit_wr;
  logic        stall;
  logic        busy;
  modport master (
    output issue_valid, issue_func3, issue_rd, issue_op1, issue_op2, pipeline_flush,
           ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_slot_free, mdu_done, mdu_result,
    input  issue_ready, mdu_start, mdu_op, mdu_a, mdu_b, m_unit_ready, m_unit_result,
           m_unit_dest, m_unit_wr, stall, busy
  );
  modport slave (
    input  issue_valid, issue_func3, issue_rd, issue_op1, issue_op2, pipeline_flush,
           ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_slot_free, mdu_done, mdu_result,
    output issue_ready, mdu_start, mdu_op, mdu_a, mdu_b, m_unit_ready, m_unit_result,
           m_unit_dest, m_unit_wr, stall, busy
  );
endinterface

// File: rtl/m_unit_scheduler.sv
// m_unit_scheduler: IDLE/RUN/WB sequencer for M ops; ports clk, rst_n (async low), bus (issue in, mdu launch/done, writeback, stall/busy out)
module m_unit_scheduler (
  input logic              clk,
  input logic              rst_n,
  m_unit_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic        start;
  logic [4:0]  rd;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        accept;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_res;
  logic        done_ok;
  logic        hazard;
  assign accept      = bus.issue_valid & bus.issue_ready & !bus.pipeline_flush;
  assign div_zero    = bus.issue_func3[2] & (bus.issue_op2 == 32'd0);
  // signed DIV/REM only (func3 100/110): most-negative / -1
  assign div_ovf     = bus.issue_func3[2] & !bus.issue_func3[0] &
                       (bus.issue_op1 == 32'h8000_0000) & (bus.issue_op2 == 32'hFFFF_FFFF);
  assign special     = div_zero | div_ovf;
  assign special_res = div_zero ? (bus.issue_func3[1] ? bus.issue_op1 : 32'hFFFF_FFFF)
                                : (bus.issue_func3[1] ? 32'd0 : 32'h8000_0000);
  // a done coinciding with the launch pulse belongs to nothing we started
  assign done_ok     = (state == RUN) & !start & bus.mdu_done;
  assign state_nx    = state == IDLE ? (accept ? (special ? WB : RUN) : IDLE) :
                       state == RUN  ? (done_ok ? WB : RUN) :
                       (bus.ex_slot_free ? IDLE : WB);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      start  <= 1'b0;
      rd     <= 5'd0;
      op     <= 3'd0;
      a      <= 32'd0;
      b      <= 32'd0;
      result <= 32'd0;
    end else begin
      state <= state_nx;
      start <= accept & !special;
      if (accept) begin
        rd <= bus.issue_rd;
        op <= bus.issue_func3;
        a  <= bus.issue_op1;
        b  <= bus.issue_op2;
      end
      if (accept & special) result <= special_res;
      else if (done_ok) result <= bus.mdu_result;
    end
  end
  assign hazard            = (rd != 5'd0) & ((bus.ex_rs1_used & (bus.ex_rs1 == rd)) |
                                             (bus.ex_rs2_used & (bus.ex_rs2 == rd)));
  assign bus.issue_ready   = state == IDLE;
  assign bus.busy          = state != IDLE;
  assign bus.mdu_start     = start;
  assign bus.mdu_op        = op;
  assign bus.mdu_a         = a;
  assign bus.mdu_b         = b;
  assign bus.m_unit_ready  = (state == WB) & bus.ex_slot_free;
  assign bus.m_unit_result = result;
  assign bus.m_unit_dest   = rd;
  assign bus.m_unit_wr     = bus.m_unit_ready & (rd != 5'd0);
  assign bus.stall         = (bus.issue_valid & !bus.issue_ready & !bus.pipeline_flush) |
                             (bus.busy & hazard);
endmodule

// File: tb/tb_m_unit_scheduler.sv
// tb_m_unit_scheduler: table, random and corner-sequence checks of m_unit_scheduler against an arithmetic M-extension model
module tb_m_unit_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  m_unit_scheduler_if bus();
  m_unit_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic [2:0]  f;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        sp;
    int          dly;
    int          hold;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] m_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin p = sa / (b == 0 ? 64'sd1 : sb); return b == 0 ? 32'hFFFF_FFFF : p[31:0]; end
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = sa % (b == 0 ? 64'sd1 : sb); return b == 0 ? a : p[31:0]; end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction
  task automatic set_hazard(input logic [4:0] rd, output logic exp);
    logic [4:0] r1, r2;
    logic u1, u2;
    r1 = $urandom_range(0, 1) ? rd : 5'($urandom);
    r2 = $urandom_range(0, 1) ? rd : 5'($urandom);
    u1 = 1'($urandom);
    u2 = 1'($urandom);
    bus.ex_rs1 = r1;
    bus.ex_rs2 = r2;
    bus.ex_rs1_used = u1;
    bus.ex_rs2_used = u2;
    exp = (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
  endtask
  task automatic issue(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    bus.issue_valid = 1'b1;
    bus.issue_func3 = f;
    bus.issue_rd = rd;
    bus.issue_op1 = a;
    bus.issue_op2 = b;
  endtask
  task automatic run_op(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic sp, input int dly, input int hold);
    logic h;
    set_hazard(rd, h);
    bus.issue_valid = 1'b0;
    bus.ex_slot_free = 1'b0;
    settle();
    chk("idle_ready", bus.issue_ready, 1);
    chk("idle_stall", bus.stall, 0);
    issue(f, rd, a, b);
    adv();
    bus.issue_valid = 1'b0;
    if (!sp) begin
      bus.mdu_done = 1'b1;
      bus.mdu_result = ~res;
      set_hazard(rd, h);
      settle();
      chk("start_pulse", bus.mdu_start, 1);
      chk("start_op", bus.mdu_op, f);
      chk("start_a", bus.mdu_a, a);
      chk("start_b", bus.mdu_b, b);
      chk("start_stall", bus.stall, h);
      adv();
      bus.mdu_done = 1'b0;
      for (int i = 1; i < dly; i++) begin
        set_hazard(rd, h);
        settle();
        chk("run_start", bus.mdu_start, 0);
        chk("run_busy", bus.busy, 1);
        chk("run_stall", bus.stall, h);
        adv();
      end
      bus.mdu_done = 1'b1;
      bus.mdu_result = res;
      settle();
      chk("done_ready", bus.m_unit_ready, 0);
      adv();
    end
    for (int i = 0; i < hold; i++) begin
      bus.mdu_done = 1'($urandom);
      bus.mdu_result = ~res;
      set_hazard(rd, h);
      settle();
      chk("wb_hold_ready", bus.m_unit_ready, 0);
      chk("wb_hold_busy", bus.busy, 1);
      chk("wb_hold_start", bus.mdu_start, 0);
      chk("wb_hold_stall", bus.stall, h);
      adv();
    end
    bus.mdu_done = 1'b0;
    bus.ex_slot_free = 1'b1;
    set_hazard(rd, h);
    settle();
    chk("wb_ready", bus.m_unit_ready, 1);
    chk("wb_result", bus.m_unit_result, res);
    chk("wb_dest", bus.m_unit_dest, rd);
    chk("wb_wr", bus.m_unit_wr, rd != 0);
    chk("wb_start", bus.mdu_start, 0);
    chk("wb_stall", bus.stall, h);
    adv();
    settle();
    chk("post_busy", bus.busy, 0);
    chk("post_ready", bus.m_unit_ready, 0);
    bus.ex_slot_free = 1'b0;
  endtask
  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    bus.issue_valid = 0; bus.issue_func3 = 0; bus.issue_rd = 0; bus.issue_op1 = 0; bus.issue_op2 = 0;
    bus.pipeline_flush = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rs1_used = 0; bus.ex_rs2_used = 0;
    bus.ex_slot_free = 0; bus.mdu_done = 0; bus.mdu_result = 0;
    rst_n = 1'b0;
    tbl[0]  = '{3'd0, 5'd5,  32'd7,          32'd6,          32'd42,         1'b0, 2, 0};
    tbl[1]  = '{3'd5, 5'd3,  32'd100,        32'd0,          32'hFFFF_FFFF,  1'b1, 1, 0};
    tbl[2]  = '{3'd6, 5'd7,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, 1, 1};
    tbl[3]  = '{3'd4, 5'd8,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1, 0};
    tbl[4]  = '{3'd7, 5'd9,  32'd123,        32'd0,          32'd123,        1'b1, 1, 0};
    tbl[5]  = '{3'd4, 5'd4,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  1'b0, 3, 4};
    tbl[6]  = '{3'd6, 5'd0,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  1'b0, 1, 0};
    tbl[7]  = '{3'd3, 5'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 2, 1};
    tbl[8]  = '{3'd1, 5'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 1, 0};
    tbl[9]  = '{3'd2, 5'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 4, 2};
    tbl[10] = '{3'd5, 5'd14, 32'd7,          32'd2,          32'd3,          1'b0, 1, 0};
    tbl[11] = '{3'd4, 5'd15, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1, 4};
    #12;
    chk("rst_ready", bus.issue_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.mdu_start, 0);
    chk("rst_op", bus.mdu_op, 0);
    chk("rst_a", bus.mdu_a, 0);
    chk("rst_b", bus.mdu_b, 0);
    chk("rst_result", bus.m_unit_result, 0);
    chk("rst_dest", bus.m_unit_dest, 0);
    chk("rst_wr", bus.m_unit_wr, 0);
    chk("rst_stall", bus.stall, 0);
    settle();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++)
      run_op(tbl[i].f, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].sp, tbl[i].dly, tbl[i].hold);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(f, 5'($urandom), a, b, m_ref(f, a, b), is_special(f, a, b), $urandom_range(1, 4), $urandom_range(0, 3));
    end
    bus.ex_rs1_used = 0;
    bus.ex_rs2_used = 0;
    issue(3'd0, 5'd6, 32'd3, 32'd4);
    adv();
    issue(3'd4, 5'd9, 32'd1, 32'd1);
    settle();
    chk("busy_stall", bus.stall, 1);
    chk("busy_ready", bus.issue_ready, 0);
    bus.pipeline_flush = 1'b1;
    #1;
    chk("busy_flush_stall", bus.stall, 0);
    adv();
    bus.issue_valid = 0;
    bus.pipeline_flush = 0;
    bus.mdu_done = 1'b1;
    bus.mdu_result = 32'd12;
    adv();
    bus.mdu_done = 1'b0;
    bus.ex_slot_free = 1'b1;
    settle();
    chk("flush_run_ready", bus.m_unit_ready, 1);
    chk("flush_run_result", bus.m_unit_result, 12);
    chk("flush_run_dest", bus.m_unit_dest, 6);
    adv();
    bus.ex_slot_free = 1'b0;
    settle();
    issue(3'd0, 5'd7, 32'd1, 32'd1);
    bus.pipeline_flush = 1'b1;
    adv();
    bus.issue_valid = 0;
    bus.pipeline_flush = 0;
    settle();
    chk("flush_idle_busy", bus.busy, 0);
    chk("flush_idle_start", bus.mdu_start, 0);
    issue(3'd0, 5'd5, 32'd7, 32'd6);
    adv();
    bus.issue_valid = 0;
    settle();
    rst_n = 1'b0;
    #1;
    chk("rst_run_busy", bus.busy, 0);
    chk("rst_run_ready", bus.issue_ready, 1);
    chk("rst_run_start", bus.mdu_start, 0);
    chk("rst_run_a", bus.mdu_a, 0);
    chk("rst_run_dest", bus.m_unit_dest, 0);
    adv();
    rst_n = 1'b1;
    bus.mdu_done = 1'b1;
    bus.mdu_result = 32'd99;
    bus.ex_slot_free = 1'b1;
    adv();
    bus.mdu_done = 1'b0;
    settle();
    chk("stale_done_ready", bus.m_unit_ready, 0);
    chk("stale_done_busy", bus.busy, 0);
    chk("stale_done_result", bus.m_unit_result, 0);
    bus.ex_slot_free = 1'b0;
    issue(3'd5, 5'd3, 32'd8, 32'd0);
    adv();
    bus.issue_valid = 0;
    settle();
    chk("wb_pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_wb_busy", bus.busy, 0);
    chk("rst_wb_result", bus.m_unit_result, 0);
    bus.ex_slot_free = 1'b1;
    #1;
    chk("rst_wb_ready", bus.m_unit_ready, 0);
    adv();
    rst_n = 1'b1;
    adv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
